rx_lane_sync_ctrl: RTL and testbench
====================================

# rx_lane_sync_ctrl

Per-lane receive bring-up controller for the Interlaken RX path. It acquires 64b/67b block lock from the 2-bit sync headers and pulses the gearbox slip until headers are aligned. It then releases the descrambler from reset, supervises the descrambler's lock with a timeout, and declares the lane up. It sits between the RX gearbox and the descrambler, driving the descrambler's SYSTEM_RESET and PASSTHROUGH inputs and consuming its LOCKED output.

## Interface
- SH_CNT_MAX, 64: consecutive valid headers required for block lock.
- SH_WINDOW, 64: header monitoring window length while block-locked.
- SH_INVALID_MAX, 16: invalid headers within one window that drop block lock.
- SLIP_WAIT, 32: cycles headers are ignored after a slip pulse.
- LOCK_TIMEOUT, 2048: cycles allowed in DESCR_WAIT for descrambler LOCKED.

Ports:
- USER_CLK  in  1  sole clock.
- SYSTEM_RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  lane enable; low forces IDLE.
- FORCE_PASSTHROUGH  in  1  bypass descrambling.
- HEADER_IN  in  2  sync header from gearbox; one header per cycle.
- DESCR_LOCKED  in  1  LOCKED from descrambler.
- GEARBOX_SLIP  out  1  one-cycle slip request.
- DESCR_RESET  out  1  drives descrambler SYSTEM_RESET.
- DESCR_PASSTHROUGH  out  1  drives descrambler PASSTHROUGH.
- BLOCK_LOCK  out  1  header alignment achieved.
- LANE_UP  out  1  lane ready for framing.
- RELOCK_CNT  out  8  saturating count of lock losses after block lock.

## Operation
- Header valid when HEADER_IN is 2'b01 or 2'b10; 2'b00/2'b11 invalid.
- States: IDLE, HUNT, SLIP_HOLD, DESCR_WAIT, UP.
- IDLE:
  - Holds while ENABLE=0.
  - ENABLE=1 -> HUNT with counters cleared.
- HUNT:
  - good_ctr counts consecutive valid headers.
  - Invalid header -> GEARBOX_SLIP=1 for one cycle, good_ctr=0, -> SLIP_HOLD.
  - good_ctr reaching SH_CNT_MAX -> DESCR_WAIT, or UP if FORCE_PASSTHROUGH=1.
- SLIP_HOLD:
  - Ignores headers for SLIP_WAIT cycles, then -> HUNT.
- DESCR_WAIT:
  - DESCR_RESET=0; timeout counter runs.
  - DESCR_LOCKED=1 -> UP.
  - Counter reaching LOCK_TIMEOUT -> HUNT (full re-align), RELOCK_CNT+1.
- UP:
  - DESCR_LOCKED falling -> DESCR_WAIT with timeout cleared, RELOCK_CNT+1, descrambler reset not reasserted (descrambler re-hunts itself).
  - In passthrough, DESCR_LOCKED is ignored.
- Window monitor, active in DESCR_WAIT and UP:
  - win_ctr counts headers 0..SH_WINDOW-1; bad_ctr counts invalid headers.
  - bad_ctr reaching SH_INVALID_MAX -> HUNT, RELOCK_CNT+1.
  - At window end both counters clear.
- Outputs per state:
  - DESCR_RESET=1 in IDLE, HUNT, SLIP_HOLD.
  - BLOCK_LOCK=1 in DESCR_WAIT and UP.
  - LANE_UP=1 only in UP.
  - DESCR_PASSTHROUGH = registered FORCE_PASSTHROUGH.
- Priority, highest first: ENABLE=0 (-> IDLE), FORCE_PASSTHROUGH change while not IDLE (-> HUNT, no RELOCK_CNT increment), header window failure, timeout / DESCR_LOCKED loss.
- Block-lock loss and descrambler-lock loss in the same cycle -> HUNT, RELOCK_CNT incremented once.
- RELOCK_CNT saturates at 255 and is cleared only by SYSTEM_RESET.

## Timing
- All outputs registered, changing on USER_CLK rising edge.
- SYSTEM_RESET asserted mid-operation: state IDLE immediately (asynchronous), all counters 0.
- Reset values: GEARBOX_SLIP=0, DESCR_RESET=1, DESCR_PASSTHROUGH=0, BLOCK_LOCK=0, LANE_UP=0, RELOCK_CNT=0.
- Input-to-output latency is one cycle: a header sampled at edge N affects state and outputs at edge N+1.
- GEARBOX_SLIP is exactly one cycle wide.
- Minimum spacing between two slip pulses is SLIP_WAIT+1 cycles.
- The SH_CNT_MAX-th consecutive valid header sets BLOCK_LOCK on the next edge.
- DESCR_RESET falls on the same edge BLOCK_LOCK rises.
- LANE_UP rises one cycle after DESCR_LOCKED is sampled high.
- Counters use the minimum width to hold their maximum value plus one; no wrap occurs before a compare fires.

## Test plan
- Clean lane: 64 headers of 2'b01, DESCR_LOCKED high 100 cycles later -> BLOCK_LOCK at cycle 65, DESCR_RESET low at cycle 65, LANE_UP one cycle after DESCR_LOCKED, no slip pulses.
- Misalignment: invalid header at cycles 10 and 50 of hunt -> two single-cycle GEARBOX_SLIP pulses; headers during each 32-cycle hold ignored; lock after 64 subsequent valid headers.
- Window failure in UP: 16 invalid headers within one 64-header window -> HUNT, LANE_UP=0 and DESCR_RESET=1 next cycle, RELOCK_CNT=1. 15 invalid headers per window indefinitely -> stays UP.
- Descrambler timeout: block lock achieved, DESCR_LOCKED held 0 -> HUNT exactly 2048 cycles after DESCR_WAIT entry, RELOCK_CNT+1. DESCR_LOCKED drop in UP -> DESCR_WAIT, DESCR_RESET stays 0.
- Passthrough: FORCE_PASSTHROUGH=1, 64 valid headers -> LANE_UP directly with DESCR_PASSTHROUGH=1, DESCR_LOCKED ignored. Toggling FORCE_PASSTHROUGH while UP -> HUNT, RELOCK_CNT unchanged.
- Reset/enable: SYSTEM_RESET pulsed mid-DESCR_WAIT, or ENABLE dropped in UP -> all outputs at reset values (RELOCK_CNT retained on ENABLE drop only); 300 forced losses -> RELOCK_CNT saturates at 255.

Source files
------------

// File: rtl/rx_lane_sync_ctrl_if.sv
// Signal bundle between the RX lane bring-up controller, the RX gearbox and the descrambler.
// The slave modport is the controller's view; the master modport is the surrounding lane logic.
interface rx_lane_sync_ctrl_if;
    logic       ENABLE;
    logic       FORCE_PASSTHROUGH;
    logic [1:0] HEADER_IN;
    logic       DESCR_LOCKED;
    logic       GEARBOX_SLIP;
    logic       DESCR_RESET;
    logic       DESCR_PASSTHROUGH;
    logic       BLOCK_LOCK;
    logic       LANE_UP;
    logic [7:0] RELOCK_CNT;

    modport master (
        output ENABLE, FORCE_PASSTHROUGH, HEADER_IN, DESCR_LOCKED,
        input  GEARBOX_SLIP, DESCR_RESET, DESCR_PASSTHROUGH, BLOCK_LOCK, LANE_UP, RELOCK_CNT
    );

    modport slave (
        input  ENABLE, FORCE_PASSTHROUGH, HEADER_IN, DESCR_LOCKED,
        output GEARBOX_SLIP, DESCR_RESET, DESCR_PASSTHROUGH, BLOCK_LOCK, LANE_UP, RELOCK_CNT
    );
endinterface

// File: rtl/rx_lane_sync_ctrl.sv
// Interlaken RX lane bring-up: 64b/67b block lock by header hunting with gearbox slip,
// then descrambler release, lock supervision with timeout, and lane-up declaration.
module rx_lane_sync_ctrl #(
    parameter int unsigned SH_CNT_MAX     = 64,
    parameter int unsigned SH_WINDOW      = 64,
    parameter int unsigned SH_INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT      = 32,
    parameter int unsigned LOCK_TIMEOUT   = 2048
) (
    input  logic               USER_CLK,
    input  logic               SYSTEM_RESET,
    rx_lane_sync_ctrl_if.slave lane
);
    localparam int unsigned GOOD_W = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned WIN_W  = $clog2(SH_WINDOW + 1);
    localparam int unsigned BAD_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int unsigned SLIP_W = $clog2(SLIP_WAIT + 1);
    localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_SLIP_HOLD,
        ST_DESCR_WAIT,
        ST_UP
    } state_t;

    state_t            state, state_nxt;
    logic [GOOD_W-1:0] good_ctr, good_nxt;
    logic [SLIP_W-1:0] slip_ctr, slip_ctr_nxt;
    logic [TO_W-1:0]   to_ctr, to_nxt;
    logic [WIN_W-1:0]  win_ctr, win_nxt;
    logic [BAD_W-1:0]  bad_ctr, bad_nxt, bad_inc;
    logic              hdr_ok;
    logic              pt_change;
    logic              in_lock;
    logic              win_end;
    logic              win_fail;
    logic              slip_nxt;
    logic              lock_loss;
    logic              pt_q;
    logic              slip_q;
    logic              descr_reset_q;
    logic              block_lock_q;
    logic              lane_up_q;
    logic [7:0]        relock_q;

    always_comb begin
        hdr_ok    = lane.HEADER_IN[1] ^ lane.HEADER_IN[0];
        pt_change = (lane.FORCE_PASSTHROUGH != pt_q);
        in_lock   = (state == ST_DESCR_WAIT) || (state == ST_UP);
        bad_inc   = bad_ctr + BAD_W'(!hdr_ok);
        win_end   = (win_ctr == WIN_W'(SH_WINDOW - 1));
        // The failing header may also be the last of its window; failure wins over the clear.
        win_fail  = in_lock && (bad_inc == BAD_W'(SH_INVALID_MAX));

        state_nxt    = state;
        good_nxt     = '0;
        slip_ctr_nxt = '0;
        to_nxt       = '0;
        win_nxt      = '0;
        bad_nxt      = '0;
        slip_nxt     = 1'b0;
        lock_loss    = 1'b0;

        if (in_lock) begin
            win_nxt = win_end ? '0 : win_ctr + WIN_W'(1);
            bad_nxt = win_end ? '0 : bad_inc;
        end

        if (!lane.ENABLE) begin
            state_nxt = ST_IDLE;
        end else if ((state != ST_IDLE) && pt_change) begin
            state_nxt = ST_HUNT;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_HUNT;
                end
                ST_HUNT: begin
                    if (!hdr_ok) begin
                        slip_nxt  = 1'b1;
                        state_nxt = ST_SLIP_HOLD;
                    end else if (good_ctr == GOOD_W'(SH_CNT_MAX - 1)) begin
                        state_nxt = lane.FORCE_PASSTHROUGH ? ST_UP : ST_DESCR_WAIT;
                    end else begin
                        good_nxt = good_ctr + GOOD_W'(1);
                    end
                end
                ST_SLIP_HOLD: begin
                    if (slip_ctr == SLIP_W'(SLIP_WAIT - 1)) begin
                        state_nxt = ST_HUNT;
                    end else begin
                        slip_ctr_nxt = slip_ctr + SLIP_W'(1);
                    end
                end
                ST_DESCR_WAIT: begin
                    if (win_fail) begin
                        state_nxt = ST_HUNT;
                        lock_loss = 1'b1;
                    end else if (lane.DESCR_LOCKED) begin
                        state_nxt = ST_UP;
                    end else if (to_ctr == TO_W'(LOCK_TIMEOUT - 1)) begin
                        state_nxt = ST_HUNT;
                        lock_loss = 1'b1;
                    end else begin
                        to_nxt = to_ctr + TO_W'(1);
                    end
                end
                ST_UP: begin
                    if (win_fail) begin
                        state_nxt = ST_HUNT;
                        lock_loss = 1'b1;
                    end else if (!pt_q && !lane.DESCR_LOCKED) begin
                        state_nxt = ST_DESCR_WAIT;
                        lock_loss = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        if ((state_nxt != ST_DESCR_WAIT) && (state_nxt != ST_UP)) begin
            win_nxt = '0;
            bad_nxt = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state         <= ST_IDLE;
            good_ctr      <= '0;
            slip_ctr      <= '0;
            to_ctr        <= '0;
            win_ctr       <= '0;
            bad_ctr       <= '0;
            pt_q          <= 1'b0;
            slip_q        <= 1'b0;
            descr_reset_q <= 1'b1;
            block_lock_q  <= 1'b0;
            lane_up_q     <= 1'b0;
            relock_q      <= '0;
        end else begin
            state         <= state_nxt;
            good_ctr      <= good_nxt;
            slip_ctr      <= slip_ctr_nxt;
            to_ctr        <= to_nxt;
            win_ctr       <= win_nxt;
            bad_ctr       <= bad_nxt;
            pt_q          <= lane.FORCE_PASSTHROUGH;
            slip_q        <= slip_nxt;
            descr_reset_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_HUNT) ||
                             (state_nxt == ST_SLIP_HOLD);
            block_lock_q  <= (state_nxt == ST_DESCR_WAIT) || (state_nxt == ST_UP);
            lane_up_q     <= (state_nxt == ST_UP);
            if (lock_loss && (relock_q != '1)) begin
                relock_q <= relock_q + 8'd1;
            end
        end
    end

    assign lane.GEARBOX_SLIP      = slip_q;
    assign lane.DESCR_RESET       = descr_reset_q;
    assign lane.DESCR_PASSTHROUGH = pt_q;
    assign lane.BLOCK_LOCK        = block_lock_q;
    assign lane.LANE_UP           = lane_up_q;
    assign lane.RELOCK_CNT        = relock_q;
endmodule

// File: tb/tb_rx_lane_sync_ctrl.sv
// Scenario bench for rx_lane_sync_ctrl: each task drives a bring-up scenario cycle by cycle,
// queues the expected output vector, and checks it against the DUT after the edge.
module tb_rx_lane_sync_ctrl;
    localparam int ST_IDLE = 0;
    localparam int ST_HUNT = 1;
    localparam int ST_SLIP = 2;
    localparam int ST_DW   = 3;
    localparam int ST_UP   = 4;

    logic USER_CLK     = 1'b0;
    logic SYSTEM_RESET = 1'b1;

    rx_lane_sync_ctrl_if lane ();

    rx_lane_sync_ctrl #(
        .SH_CNT_MAX    (64),
        .SH_WINDOW     (64),
        .SH_INVALID_MAX(16),
        .SLIP_WAIT     (32),
        .LOCK_TIMEOUT  (2048)
    ) dut (
        .USER_CLK    (USER_CLK),
        .SYSTEM_RESET(SYSTEM_RESET),
        .lane        (lane.slave)
    );

    always #5 USER_CLK = ~USER_CLK;

    logic [12:0] exp_q[$];
    logic [12:0] expv;
    int          nvec = 0;
    int          nmis = 0;
    int          cur_st = ST_IDLE;
    int          wpos = 0;
    int          relock_exp = 0;
    bit          pt = 1'b0;

    // {GEARBOX_SLIP, DESCR_RESET, DESCR_PASSTHROUGH, BLOCK_LOCK, LANE_UP, RELOCK_CNT}
    function automatic logic [12:0] outs();
        return {lane.GEARBOX_SLIP, lane.DESCR_RESET, lane.DESCR_PASSTHROUGH,
                lane.BLOCK_LOCK, lane.LANE_UP, lane.RELOCK_CNT};
    endfunction

    function automatic logic [12:0] decode(input int st, input bit slip, input bit ptv, input int rc);
        logic dr, bl, up;
        dr = (st == ST_IDLE) || (st == ST_HUNT) || (st == ST_SLIP);
        bl = (st == ST_DW) || (st == ST_UP);
        up = (st == ST_UP);
        return {slip, dr, ptv, bl, up, 8'(rc)};
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected right after the edge.
    task automatic drive(input bit en, input logic [1:0] hdr, input bit lk,
                         input int nxt, input bit slip, input bit loss);
        lane.ENABLE            = en;
        lane.HEADER_IN         = hdr;
        lane.DESCR_LOCKED      = lk;
        lane.FORCE_PASSTHROUGH = pt;
        if (loss && relock_exp < 255) relock_exp++;
        if (cur_st == ST_DW || cur_st == ST_UP) wpos = (wpos + 1) % 64;
        else wpos = 0;
        cur_st = nxt;
        exp_q.push_back(decode(nxt, slip, pt, relock_exp));
        @(posedge USER_CLK);
        #1;
    endtask

    task automatic test_reset();
        lane.ENABLE = 1'b0; lane.HEADER_IN = 2'b01; lane.DESCR_LOCKED = 1'b0;
        lane.FORCE_PASSTHROUGH = 1'b0; pt = 1'b0;
        repeat (2) @(posedge USER_CLK);
        #1;
        exp_q.push_back(decode(ST_IDLE, 0, 0, 0));
        expv = exp_q.pop_front(); nvec++;
        if (outs() !== expv) begin
            nmis++; $display("FAIL reset_values: got %h, want %h", outs(), expv);
        end
        SYSTEM_RESET = 1'b0;
        cur_st = ST_IDLE; relock_exp = 0; wpos = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            drive(0, 2'b11, 1, ST_IDLE, 0, 0);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL idle_hold[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
    endtask

    // Enable, 64 clean headers, 100 cycles without descrambler lock, then lock.
    task automatic test_clean();
        for (int unsigned i = 0; i < 171; i++) begin
            int nxt;
            nxt = (i < 64) ? ST_HUNT : ((i < 165) ? ST_DW : ST_UP);
            drive(1, 2'b01, (i >= 165), nxt, 0, 0);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL clean[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
    endtask

    // 15 invalid per window (straddling a boundary) keeps UP; 16 in one window drops to HUNT,
    // with a simultaneous descrambler lock loss counted once.
    task automatic test_window();
        for (int unsigned i = 0; i < 64 && wpos != 0; i++) begin
            drive(1, 2'b10, 1, ST_UP, 0, 0);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL win_align[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
        for (int unsigned k = 0; k < 192; k++) begin
            int unsigned p, w;
            bit bad, last;
            p = k % 64; w = k / 64;
            bad  = (w == 0 && p >= 49) || (w == 1 && p < 15) || (w == 2 && p >= 48);
            last = (k == 191);
            drive(1, bad ? ((k % 2) ? 2'b11 : 2'b00) : 2'b01, !last,
                  last ? ST_HUNT : ST_UP, 0, last);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL window[%0d]: got %h, want %h", k, outs(), expv);
            end
        end
    endtask

    // Two slips with ignored headers during each hold, then lock on 64 fresh valid headers.
    task automatic test_misalign();
        int unsigned seg_n [10] = '{9, 1, 31, 1, 7, 1, 31, 1, 63, 1};
        logic [1:0]  seg_h [10] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10};
        int          seg_s [10] = '{ST_HUNT, ST_SLIP, ST_SLIP, ST_HUNT, ST_HUNT,
                                    ST_SLIP, ST_SLIP, ST_HUNT, ST_HUNT, ST_DW};
        bit          seg_p [10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int unsigned s = 0; s < 10; s++) begin
            for (int unsigned i = 0; i < seg_n[s]; i++) begin
                drive(1, seg_h[s], 0, seg_s[s], seg_p[s], 0);
                expv = exp_q.pop_front(); nvec++;
                if (outs() !== expv) begin
                    nmis++; $display("FAIL misalign[%0d.%0d]: got %h, want %h", s, i, outs(), expv);
                end
            end
        end
    endtask

    // Lock timeout exactly 2048 cycles after DESCR_WAIT entry; lock drop in UP keeps DESCR_RESET low.
    task automatic test_timeout();
        for (int unsigned i = 0; i < 2048 + 64 + 6; i++) begin
            int nxt; bit lk, loss;
            lk = 0; loss = 0;
            if (i < 2047) nxt = ST_DW;
            else if (i == 2047) begin nxt = ST_HUNT; loss = 1; end
            else if (i < 2048 + 63) nxt = ST_HUNT;
            else if (i == 2048 + 63) nxt = ST_DW;
            else if (i == 2048 + 64) begin nxt = ST_UP; lk = 1; end
            else if (i == 2048 + 65) begin nxt = ST_DW; loss = 1; end
            else if (i < 2048 + 68) nxt = ST_DW;
            else begin nxt = ST_UP; lk = 1; end
            drive(1, 2'b01, lk, nxt, 0, loss);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL timeout[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
    endtask

    // Passthrough toggles force HUNT without counting; passthrough lock ignores DESCR_LOCKED.
    task automatic test_passthrough();
        for (int unsigned i = 0; i < 86; i++) begin
            int nxt;
            if (i == 0) pt = 1'b1;
            if (i == 85) pt = 1'b0;
            nxt = (i == 0 || i == 85 || i < 64) ? ST_HUNT : ST_UP;
            drive(1, 2'b10, (i > 64) ? 1'($urandom_range(0, 1)) : 1'b0, nxt, 0, 0);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL passthru[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
    endtask

    // ENABLE drop from UP returns outputs to reset values except the retained relock count.
    task automatic test_enable();
        for (int unsigned i = 0; i < 68; i++) begin
            int nxt;
            nxt = (i < 63) ? ST_HUNT : ((i == 63) ? ST_DW : ((i == 64) ? ST_UP : ST_IDLE));
            drive((i < 65), 2'b01, 1, nxt, 0, 0);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL enable[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
    endtask

    // Asynchronous reset in the middle of DESCR_WAIT, between clock edges.
    task automatic test_reset_mid();
        for (int unsigned i = 0; i < 75; i++) begin
            drive(1, 2'b01, 0, (i < 64) ? ST_HUNT : ST_DW, 0, 0);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL reset_mid_pre[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
        #2;
        SYSTEM_RESET = 1'b1;
        #1;
        relock_exp = 0; cur_st = ST_IDLE; wpos = 0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (i == 1) begin @(posedge USER_CLK); #1; end
            exp_q.push_back(decode(ST_IDLE, 0, 0, 0));
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL reset_mid[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
        SYSTEM_RESET = 1'b0;
    endtask

    // 300 descrambler lock losses from UP; the count must stop at 255.
    task automatic test_saturate();
        for (int unsigned i = 0; i < 66 + 600; i++) begin
            int nxt; bit lk, loss;
            loss = 0;
            if (i < 64) begin nxt = ST_HUNT; lk = 0; end
            else if (i == 64) begin nxt = ST_DW; lk = 0; end
            else if (i == 65) begin nxt = ST_UP; lk = 1; end
            else if ((i % 2) == 0) begin nxt = ST_DW; lk = 0; loss = 1; end
            else begin nxt = ST_UP; lk = 1; end
            drive(1, 2'b01, lk, nxt, 0, loss);
            expv = exp_q.pop_front(); nvec++;
            if (outs() !== expv) begin
                nmis++; $display("FAIL saturate[%0d]: got %h, want %h", i, outs(), expv);
            end
        end
        nvec++;
        if (lane.RELOCK_CNT !== 8'd255) begin
            nmis++; $display("FAIL relock_sat: got %0d, want 255", lane.RELOCK_CNT);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_window();
        test_misalign();
        test_timeout();
        test_passthrough();
        test_enable();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
